// File: rtl/mtr_drv_pkg.sv
// mtr_drv_pkg: shared types and constants for the dual H-bridge PWM driver.
//   dt_state_t  : dead-time FSM states
//   PERIOD_W    : width of the PWM period counter (2048-clock period)
//   DUTY_RST    : duty loaded at reset (50 %, zero speed)
//   CNT_LAST    : last count of a period, where duty buffers reload
//   spd_to_duty : offset-binary conversion of a signed speed command
package mtr_drv_pkg;

  localparam int PERIOD_W = 11;
  localparam logic [PERIOD_W-1:0] DUTY_RST = 11'h400;
  localparam logic [PERIOD_W-1:0] CNT_LAST = 11'h7FF;

  typedef enum logic [1:0] {
    BOTH_OFF = 2'd0,
    HI_ON    = 2'd1,
    LO_ON    = 2'd2
  } dt_state_t;

  // Takes spd[11:1]; flipping the sign bit turns two's complement into
  // offset binary, so zero speed lands at mid-scale.
  function automatic logic [PERIOD_W-1:0] spd_to_duty(input logic [10:0] spd_hi);
    return {~spd_hi[10], spd_hi[9:0]};
  endfunction

endpackage

// File: rtl/mtr_drv_if.sv
// mtr_drv_if: command and gate bundle between the Segway math stage and mtr_drv.
//   lft_spd/rght_spd       : signed 12-bit wheel speed commands
//   OVR_I_lft/OVR_I_rght   : over-current comparators, active-high
//   lft_PWM1/2, rght_PWM1/2: high-side / low-side gate drives
//   PWM_synch              : one-clock pulse at period start
//   OVR_I_shtdwn           : latched over-current shutdown
// master = command source, slave = mtr_drv.
interface mtr_drv_if;

  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        OVR_I_lft;
  logic        OVR_I_rght;
  logic        lft_PWM1;
  logic        lft_PWM2;
  logic        rght_PWM1;
  logic        rght_PWM2;
  logic        PWM_synch;
  logic        OVR_I_shtdwn;

  modport master (
    output lft_spd, rght_spd, OVR_I_lft, OVR_I_rght,
    input  lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, OVR_I_shtdwn
  );

  modport slave (
    input  lft_spd, rght_spd, OVR_I_lft, OVR_I_rght,
    output lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, OVR_I_shtdwn
  );

endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: one motor channel -- double-buffered duty, registered raw PWM,
// dead-time FSM driving a complementary gate pair, and (with
// MTR_DRV_OVR_I_EN) a per-period over-current fault flag.
// Ports:
//   clk, rst   : clock, async active-high reset
//   cnt, wrap  : shared period counter and its last-count strobe
//   spd_hi     : speed command bits [11:1]
//   ovr_i      : over-current comparator        (MTR_DRV_OVR_I_EN only)
//   armed      : counter is past the blank window (MTR_DRV_OVR_I_EN only)
//   kill       : force both gates low             (MTR_DRV_OVR_I_EN only)
//   fault      : fault seen this period           (MTR_DRV_OVR_I_EN only)
//   pwm1, pwm2 : high-side / low-side gates, registered
module pwm_deadtime
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_CYC = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] cnt,
  input  logic                wrap,
  input  logic [10:0]         spd_hi,
`ifdef MTR_DRV_OVR_I_EN
  input  logic                ovr_i,
  input  logic                armed,
  input  logic                kill,
  output logic                fault,
`endif
  output logic                pwm1,
  output logic                pwm2
);

  localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 32'sd1);

  logic [PERIOD_W-1:0] duty_r;
  logic                raw_r;
  logic                raw_d_r;
  logic                raw_chg_s;
  logic                kill_s;
  dt_state_t           state_r;
  dt_state_t           state_nxt_s;
  logic [7:0]          dead_cnt_r;
  logic [7:0]          dead_cnt_nxt_s;

  assign raw_chg_s = raw_r ^ raw_d_r;

`ifdef MTR_DRV_OVR_I_EN
  logic fault_r;
  logic fault_now_s;

  assign kill_s      = kill;
  assign fault_now_s = ovr_i & armed & (pwm1 | pwm2);
  // Include the current cycle so a fault on the last count still counts.
  assign fault       = fault_r | fault_now_s;

  // Per-period fault flag, cleared as each period closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else if (wrap) begin
      fault_r <= 1'b0;
    end else if (fault_now_s) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end
`else
  assign kill_s = 1'b0;
`endif

  // Duty buffer: a new command only takes effect from the next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r <= DUTY_RST;
    end else if (wrap) begin
      duty_r <= spd_to_duty(spd_hi);
    end else begin
      duty_r <= duty_r;
    end
  end

  // Raw PWM comparator and its delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_r   <= 1'b0;
      raw_d_r <= 1'b0;
    end else begin
      raw_r   <= (cnt < duty_r);
      raw_d_r <= raw_r;
    end
  end

  // Dead-time next-state: every raw edge restarts the dead window from BOTH_OFF.
  always_comb begin
    state_nxt_s    = state_r;
    dead_cnt_nxt_s = dead_cnt_r;
    case (state_r)
      BOTH_OFF: begin
        if (raw_chg_s) begin
          dead_cnt_nxt_s = 8'd0;
        end else if (dead_cnt_r == DEAD_LAST) begin
          dead_cnt_nxt_s = 8'd0;
          state_nxt_s    = raw_r ? HI_ON : LO_ON;
        end else begin
          dead_cnt_nxt_s = dead_cnt_r + 8'd1;
        end
      end
      HI_ON, LO_ON: begin
        if (raw_chg_s) begin
          state_nxt_s    = BOTH_OFF;
          dead_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s    = state_r;
          dead_cnt_nxt_s = 8'd0;
        end
      end
      default: begin
        state_nxt_s    = BOTH_OFF;
        dead_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // State register; gates are decoded from the next state so they are
  // registered yet aligned with the state they represent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= BOTH_OFF;
      dead_cnt_r <= 8'd0;
      pwm1       <= 1'b0;
      pwm2       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      dead_cnt_r <= dead_cnt_nxt_s;
      pwm1       <= (state_nxt_s == HI_ON) & ~kill_s;
      pwm2       <= (state_nxt_s == LO_ON) & ~kill_s;
    end
  end

endmodule

// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM generator with dead time and period sync.
// Optional over-current shutdown is built when MTR_DRV_OVR_I_EN is defined;
// otherwise OVR_I inputs are ignored and OVR_I_shtdwn is tied low.
// Parameters: DEAD_CYC (1..255), BLANK_CYC, OVR_LIMIT (1..7).
// Ports:
//   clk : system clock
//   rst : async active-high reset
//   bus : mtr_drv_if.slave (speed commands, OVR_I inputs, gates, sync, shutdown)
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_CYC  = 32,
  parameter int BLANK_CYC = 128,
  parameter int OVR_LIMIT = 4
) (
  input logic       clk,
  input logic       rst,
  mtr_drv_if.slave  bus
);

  logic [PERIOD_W-1:0] cnt_r;
  logic                wrap_s;
  logic                synch_r;
  logic                lft_pwm1_s;
  logic                lft_pwm2_s;
  logic                rght_pwm1_s;
  logic                rght_pwm2_s;
  logic                unused_s;

  assign wrap_s = (cnt_r == CNT_LAST);

  // Free-running period counter; wraps naturally from 2047 to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {PERIOD_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + 11'd1;
    end
  end

  // Sync registered on the last count so it is high while cnt is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      synch_r <= 1'b0;
    end else begin
      synch_r <= wrap_s;
    end
  end

`ifdef MTR_DRV_OVR_I_EN
  localparam logic [PERIOD_W-1:0] BLANK_L   = PERIOD_W'(BLANK_CYC);
  localparam logic [2:0]          OVR_LIM_L = 3'(OVR_LIMIT);

  logic       armed_s;
  logic       fault_lft_s;
  logic       fault_rght_s;
  logic [2:0] ovr_cnt_r;
  logic [2:0] ovr_cnt_nxt_s;
  logic       shtdwn_r;
  logic       shtdwn_nxt_s;

  assign armed_s = (cnt_r >= BLANK_L);

  // Consecutive-faulted-period counter and sticky shutdown decision.
  always_comb begin
    ovr_cnt_nxt_s = ovr_cnt_r;
    shtdwn_nxt_s  = shtdwn_r;
    if (wrap_s) begin
      if (fault_lft_s | fault_rght_s) begin
        if (ovr_cnt_r != 3'd7) begin
          ovr_cnt_nxt_s = ovr_cnt_r + 3'd1;
        end else begin
          ovr_cnt_nxt_s = ovr_cnt_r;
        end
      end else begin
        ovr_cnt_nxt_s = 3'd0;
      end
    end else begin
      ovr_cnt_nxt_s = ovr_cnt_r;
    end
    if (ovr_cnt_nxt_s >= OVR_LIM_L) begin
      shtdwn_nxt_s = 1'b1;
    end else begin
      shtdwn_nxt_s = shtdwn_r;
    end
  end

  // Shutdown state; only rst clears the latched flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_cnt_r <= 3'd0;
      shtdwn_r  <= 1'b0;
    end else begin
      ovr_cnt_r <= ovr_cnt_nxt_s;
      shtdwn_r  <= shtdwn_nxt_s;
    end
  end

  assign bus.OVR_I_shtdwn = shtdwn_r;
  assign unused_s = ^{bus.lft_spd[0], bus.rght_spd[0]};
`else
  assign bus.OVR_I_shtdwn = 1'b0;
  assign unused_s = ^{bus.lft_spd[0], bus.rght_spd[0], bus.OVR_I_lft, bus.OVR_I_rght,
                      BLANK_CYC[0], OVR_LIMIT[0]};
`endif

  pwm_deadtime #(.DEAD_CYC(DEAD_CYC)) u_lft (
    .clk    (clk),
    .rst    (rst),
    .cnt    (cnt_r),
    .wrap   (wrap_s),
    .spd_hi (bus.lft_spd[11:1]),
`ifdef MTR_DRV_OVR_I_EN
    .ovr_i  (bus.OVR_I_lft),
    .armed  (armed_s),
    .kill   (shtdwn_nxt_s),
    .fault  (fault_lft_s),
`endif
    .pwm1   (lft_pwm1_s),
    .pwm2   (lft_pwm2_s)
  );

  pwm_deadtime #(.DEAD_CYC(DEAD_CYC)) u_rght (
    .clk    (clk),
    .rst    (rst),
    .cnt    (cnt_r),
    .wrap   (wrap_s),
    .spd_hi (bus.rght_spd[11:1]),
`ifdef MTR_DRV_OVR_I_EN
    .ovr_i  (bus.OVR_I_rght),
    .armed  (armed_s),
    .kill   (shtdwn_nxt_s),
    .fault  (fault_rght_s),
`endif
    .pwm1   (rght_pwm1_s),
    .pwm2   (rght_pwm2_s)
  );

  assign bus.lft_PWM1  = lft_pwm1_s;
  assign bus.lft_PWM2  = lft_pwm2_s;
  assign bus.rght_PWM1 = rght_pwm1_s;
  assign bus.rght_PWM2 = rght_pwm2_s;
  assign bus.PWM_synch = synch_r;

endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: directed self-checking bench for mtr_drv (DEAD_CYC=32).
// Counts gate-high clocks per 2048-clock period against hand-derived values.
module tb_mtr_drv;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mtr_drv_if bus ();

  mtr_drv #(.DEAD_CYC(32), .BLANK_CYC(128), .OVR_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bench copy of the period counter, advanced from the bench's own clock/reset.
  logic [10:0] cnt_m;
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_m <= 11'd0;
    else     cnt_m <= cnt_m + 11'd1;
  end

  int checks   = 0;
  int failures = 0;

  int h1l, h2l, h1r, h2r, ovl, syn, synbad, shd;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_cnt(input logic [10:0] v);
    int n = 0;
    while (cnt_m !== v && n < 4096) begin
      @(negedge clk);
      n++;
    end
    if (cnt_m !== v) check_val("wait_cnt", int'(cnt_m), int'(v));
  endtask

  // One full period sampled on negedges starting at cnt==0.
  // ovr_mode: 1 = raise OVR_I_lft at cnt 200, 2 = high only below cnt 128,
  //           3 = high for the whole period unless pidx==3.
  task automatic measure(input int chg_at, input logic [11:0] chg_val,
                         input int ovr_mode, input int pidx);
    h1l = 0; h2l = 0; h1r = 0; h2r = 0; ovl = 0; syn = 0; synbad = 0; shd = 0;
    wait_cnt(11'd0);
    for (int i = 0; i < 2048; i++) begin
      if (i == chg_at) bus.lft_spd = chg_val;
      case (ovr_mode)
        1: if (i == 200) bus.OVR_I_lft = 1'b1;
        2: bus.OVR_I_lft = (i < 128);
        3: bus.OVR_I_lft = (pidx != 3);
        default: ;
      endcase
      h1l += int'(bus.lft_PWM1);
      h2l += int'(bus.lft_PWM2);
      h1r += int'(bus.rght_PWM1);
      h2r += int'(bus.rght_PWM2);
      if (bus.lft_PWM1 && bus.lft_PWM2)   ovl++;
      if (bus.rght_PWM1 && bus.rght_PWM2) ovl++;
      if (bus.PWM_synch) begin
        syn++;
        if (i != 0) synbad++;
      end
      shd += int'(bus.OVR_I_shtdwn);
      @(negedge clk);
    end
  endtask

  task automatic check_period(input string tg, input int el1, input int el2,
                              input int er1, input int er2);
    check_val({tg, "_lft_hi"},  h1l, el1);
    check_val({tg, "_lft_lo"},  h2l, el2);
    check_val({tg, "_rght_hi"}, h1r, er1);
    check_val({tg, "_rght_lo"}, h2r, er2);
    check_val({tg, "_overlap"}, ovl, 0);
    check_val({tg, "_synch"},   syn * 16 + synbad, 16);
  endtask

  // Release reset at a negedge; gates must stay low for 33 clocks, then the
  // left high side (duty 0x400 after reset) rises on the 34th.
  task automatic release_quiet(input string tag);
    int q = 0;
    rst = 1'b0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      q += int'(bus.lft_PWM1 | bus.lft_PWM2 | bus.rght_PWM1 | bus.rght_PWM2);
    end
    check_val({tag, "_quiet"}, q, 0);
    @(negedge clk);
    check_val({tag, "_first_hi"}, int'(bus.lft_PWM1), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int shd_sum;
    bus.lft_spd    = 12'h000;
    bus.rght_spd   = 12'h000;
    bus.OVR_I_rght = 1'b0;
`ifdef MTR_DRV_OVR_I_EN
    bus.OVR_I_lft  = 1'b0;
`else
    bus.OVR_I_lft  = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check_val("rst_outs", int'({bus.lft_PWM1, bus.lft_PWM2, bus.rght_PWM1, bus.rght_PWM2,
                                bus.PWM_synch, bus.OVR_I_shtdwn}), 0);
    release_quiet("boot");

    // Zero speed: 992/992 on both sides.
    measure(-1, 12'h000, 0, 0); check_period("idle1", 992, 992, 992, 992);
    measure(-1, 12'h000, 0, 0); check_period("idle2", 992, 992, 992, 992);
    check_val("idle_shtdwn", shd, 0);

    // Mid-period left change waits for the next period (duty 0x600).
    measure(500, 12'h400, 0, 0); check_period("chg_cur", 992, 992, 992, 992);
    measure(-1, 12'h400, 0, 0);  check_period("chg_next", 1504, 480, 992, 992);

    // Right full reverse, then full forward.
    bus.rght_spd = 12'h800;
    measure(-1, 12'h400, 0, 0); check_period("r800_cur", 1504, 480, 992, 992);
    bus.rght_spd = 12'h7FF;
    measure(-1, 12'h400, 0, 0); check_period("r800", 1504, 480, 0, 2048);
    measure(-1, 12'h400, 0, 0); check_period("r7ff_first", 1504, 480, 2014, 2);
    measure(-1, 12'h400, 0, 0); check_period("r7ff", 1504, 480, 2015, 0);

    // Asynchronous reset while lft_PWM1 is high.
    wait_cnt(11'd800);
    check_val("pre_rst_hi", int'(bus.lft_PWM1), 1);
    #1 rst = 1'b1;
    #1 check_val("rst_async", int'({bus.lft_PWM1, bus.lft_PWM2, bus.rght_PWM1, bus.rght_PWM2,
                                    bus.PWM_synch, bus.OVR_I_shtdwn}), 0);
    repeat (2) @(negedge clk);
    release_quiet("rerst");
    bus.lft_spd  = 12'h000;
    bus.rght_spd = 12'h000;

`ifdef MTR_DRV_OVR_I_EN
    // Fault from cnt 200 every period: trips at the 4th wrap.
    shd_sum = 0;
    for (int p = 0; p < 4; p++) begin
      measure(-1, 12'h000, 1, p);
      shd_sum += shd;
    end
    check_val("ovr_pre_trip", shd_sum, 0);
    measure(-1, 12'h000, 0, 0);
    check_val("ovr_tripped", shd, 2048);
    check_val("ovr_gates_off", h1l + h2l + h1r + h2r, 0);
    bus.OVR_I_lft = 1'b0;
    pulse_reset();

    // Fault only inside the blank window: never trips.
    shd_sum = 0;
    for (int p = 0; p < 5; p++) begin
      measure(-1, 12'h000, 2, p);
      shd_sum += shd;
    end
    measure(-1, 12'h000, 0, 0);
    check_val("ovr_blanked", shd_sum + shd, 0);

    // 3 faulted, 1 clean, 3 faulted: counter restarts, never trips.
    shd_sum = 0;
    for (int p = 0; p < 7; p++) begin
      measure(-1, 12'h000, 3, p);
      shd_sum += shd;
    end
    bus.OVR_I_lft = 1'b0;
    measure(-1, 12'h000, 0, 0);
    check_val("ovr_broken_run", shd_sum + shd, 0);
    check_period("ovr_after", 992, 992, 992, 992);
`else
    // OVR_I_lft remains high: still no shutdown and normal PWM.
    measure(-1, 12'h000, 0, 0);
    measure(-1, 12'h000, 0, 0);
    check_period("noovr", 992, 992, 992, 992);
    check_val("noovr_shtdwn", shd, 0);
    shd_sum = 0;
    check_val("noovr_sum", shd_sum, shd);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
